pss_board_io: RTL and testbench

Parametrised board-I/O conditioning block that sits between the board pins and the PSS GPIO ports: per-channel switch synchronisation, debouncing and edge detection on the input side, and per-channel LED drive modes (direct, blink, PWM-dim, off) on the output side. It replaces the raw pin-to-GPIO wiring in the board tops. It is generalised in channel count, debounce interval and dimming resolution.

---
 rtl/pss_board_io.sv | 121 ++++++++++++
 tb/tb_pss_board_io.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pss_board_io.sv
`default_nettype none
// ============================================================================
// Module   : pss_board_io
// Purpose  : switch sync/debounce/edge detect and per-channel LED drive modes
// Revision : 1.0 - initial release
// ============================================================================
module pss_board_io #(
  parameter int SW_WIDTH  = 16,
  parameter int LED_WIDTH = 16,
  parameter int DB_CYCLES = 100000,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 24
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [SW_WIDTH-1:0]    sw_i,
  output logic [SW_WIDTH-1:0]    sw_o,
  output logic [SW_WIDTH-1:0]    sw_rise_o,
  output logic [SW_WIDTH-1:0]    sw_fall_o,
  input  logic [LED_WIDTH-1:0]   led_i,
  input  logic [2*LED_WIDTH-1:0] led_mode_i,
  input  logic [PWM_BITS-1:0]    pwm_duty_i,
  output logic [LED_WIDTH-1:0]   led_o
);

  localparam int              CNT_W     = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] C_MODE_DIRECT = 2'b00;
  localparam logic [1:0] C_MODE_BLINK  = 2'b01;
  localparam logic [1:0] C_MODE_DIM    = 2'b10;

  logic [SW_WIDTH-1:0] s1_q, s2_q;
  logic [SW_WIDTH-1:0] db_q, db_d;
  logic [SW_WIDTH-1:0] rise_q, rise_d;
  logic [SW_WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0]    cnt_q [SW_WIDTH];
  logic [CNT_W-1:0]    cnt_d [SW_WIDTH];

  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic [BLINK_DIV-1:0] blink_cnt_q;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 pwm_on;
  logic                 blink_on;

  // Any cycle where the synchronised level agrees with the accepted one
  // restarts the interval, so only an unbroken run gets accepted.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == C_DB_LAST) begin
          db_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= sw_i;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < SW_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pwm_on   = (pwm_cnt_q < pwm_duty_i);
  assign blink_on = blink_cnt_q[BLINK_DIV-1];

  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_WIDTH; i++) begin
      case (led_mode_i[2*i +: 2])
        C_MODE_DIRECT: led_d[i] = led_i[i];
        C_MODE_BLINK:  led_d[i] = led_i[i] & blink_on;
        C_MODE_DIM:    led_d[i] = led_i[i] & pwm_on;
        default:       led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      led_q       <= '0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_q + 1'b1;
      blink_cnt_q <= blink_cnt_q + 1'b1;
      led_q       <= led_d;
    end
  end

  assign sw_o      = db_q;
  assign sw_rise_o = rise_q;
  assign sw_fall_o = fall_q;
  assign led_o     = led_q;

endmodule
`default_nettype wire

// File: tb/tb_pss_board_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_pss_board_io
// Purpose  : self-checking bench for pss_board_io (4 channels, short timings)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pss_board_io;

  localparam int DB = 4;

  logic       clk  = 1'b0;
  logic       arst = 1'b1;
  logic [3:0] sw   = '0;
  logic [3:0] led  = '0;
  logic [7:0] mode = '0;
  logic [3:0] duty = '0;
  logic [3:0] sw_o, rise, fall, led_o;

  always #5 clk = ~clk;

  pss_board_io #(
    .SW_WIDTH (4),
    .LED_WIDTH(4),
    .DB_CYCLES(DB),
    .PWM_BITS (4),
    .BLINK_DIV(4)
  ) u_dut (
    .clk_i     (clk),
    .arst_i    (arst),
    .sw_i      (sw),
    .sw_o      (sw_o),
    .sw_rise_o (rise),
    .sw_fall_o (fall),
    .led_i     (led),
    .led_mode_i(mode),
    .pwm_duty_i(duty),
    .led_o     (led_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: an input level is accepted once the twice-delayed pin
  // has disagreed with it for DB consecutive edges; LEDs derive from a
  // global cycle count since reset.
  logic [3:0] m_d1 = '0, m_d2 = '0, m_sw = '0, m_rise = '0, m_fall = '0, m_led = '0;
  int         m_run[4] = '{default: 0};
  int         m_tick   = 0;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_d1 = '0; m_d2 = '0; m_sw = '0; m_rise = '0; m_fall = '0; m_led = '0;
      for (int c = 0; c < 4; c++) m_run[c] = 0;
      m_tick = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < 4; c++) begin
        if (m_d2[c] !== m_sw[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_sw[c] = m_d2[c];
            if (m_d2[c]) m_rise[c] = 1'b1;
            else         m_fall[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = sw;
      for (int c = 0; c < 4; c++) begin
        case (mode[2*c +: 2])
          2'b00:   m_led[c] = led[c];
          2'b01:   m_led[c] = led[c] & ((m_tick % 16) >= 8);
          2'b10:   m_led[c] = led[c] & ((m_tick % 16) < int'(duty));
          default: m_led[c] = 1'b0;
        endcase
      end
      m_tick++;
    end
  end

  logic glitch_seen = 1'b0;
  always @(negedge clk) glitch_seen <= glitch_seen | sw_o[1] | rise[1] | fall[1];

  typedef struct {
    logic [7:0]      mode;
    logic [3:0]      led;
    logic [3:0]      duty;
    logic [3:0][4:0] exp_on;   // high cycles per 16, channels 3..0
  } vec_t;

  vec_t vt[5];

  initial begin
    int hit, at, cnt;
    int on[4];

    vt[0] = '{8'hAA, 4'hF, 4'd4,  {5'd4,  5'd4,  5'd4,  5'd4}};
    vt[1] = '{8'hAA, 4'hF, 4'd0,  {5'd0,  5'd0,  5'd0,  5'd0}};
    vt[2] = '{8'hAA, 4'hF, 4'd15, {5'd15, 5'd15, 5'd15, 5'd15}};
    vt[3] = '{8'hD2, 4'hF, 4'd8,  {5'd0,  5'd8,  5'd16, 5'd8}};
    vt[4] = '{8'h00, 4'h5, 4'd8,  {5'd0,  5'd16, 5'd0,  5'd16}};

    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {16'h0, sw_o, rise, fall, led_o}, 32'h0);
    @(negedge clk) arst = 1'b0;
    repeat (2) @(negedge clk);

    // Debounce accept then release on channel 0
    sw[0] = 1'b1;
    hit = -1; at = -1; cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (sw_o[0] && hit < 0) hit = n;
      if (rise[0]) begin cnt++; at = n; end
    end
    check("accept_latency", hit, 5);
    check("rise_count", cnt, 1);
    check("rise_edge", at, 5);
    @(negedge clk) sw[0] = 1'b0;
    hit = -1; at = -1; cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (!sw_o[0] && hit < 0) hit = n;
      if (fall[0]) begin cnt++; at = n; end
    end
    check("release_latency", hit, 5);
    check("fall_count", cnt, 1);
    check("fall_edge", at, 5);

    // Glitch reject on channel 1
    @(negedge clk) glitch_seen = 1'b0;
    sw[1] = 1'b1; repeat (3) @(negedge clk);
    sw[1] = 1'b0; @(negedge clk);
    sw[1] = 1'b1; repeat (3) @(negedge clk);
    sw[1] = 1'b0; repeat (10) @(negedge clk);
    check("glitch_reject", {31'h0, glitch_seen}, 32'h0);

    // Reset in the middle of a debounce interval on channel 2
    sw = 4'b0100;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    #1 check("midrst_outputs_a", {16'h0, sw_o, rise, fall, led_o}, 32'h0);
    repeat (2) @(negedge clk);
    check("midrst_outputs_b", {16'h0, sw_o, rise, fall, led_o}, 32'h0);
    arst = 1'b0;
    hit = -1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (sw_o[2] && hit < 0) hit = n;
    end
    check("midrst_latency", hit, 5);
    @(negedge clk) sw = '0;
    repeat (10) @(negedge clk);

    // LED duty/mode table: 16 consecutive cycles cover every counter phase
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      mode = vt[v].mode; led = vt[v].led; duty = vt[v].duty;
      @(posedge clk);
      for (int c = 0; c < 4; c++) on[c] = 0;
      for (int s = 0; s < 16; s++) begin
        @(posedge clk); #1;
        check($sformatf("led_model_v%0d_s%0d", v, s), {28'h0, led_o}, {28'h0, m_led});
        for (int c = 0; c < 4; c++) on[c] += int'(led_o[c]);
      end
      for (int c = 0; c < 4; c++)
        check($sformatf("led_on_count_v%0d_ch%0d", v, c), on[c], int'(vt[v].exp_on[c]));
    end

    // Asynchronous reset drops active LEDs before any clock edge
    @(negedge clk); mode = 8'h00; led = 4'hF;
    @(posedge clk); #1 check("led_direct_on", {28'h0, led_o}, 32'hF);
    @(negedge clk); #2 arst = 1'b1;
    #1 check("led_async_drop", {28'h0, led_o}, 32'h0);
    @(negedge clk) arst = 1'b0;

    // Randomised traffic against the reference model
    for (int r = 0; r < 400; r++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) sw[c] = ~sw[c];
      led = 4'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 15) == 0) duty = 4'($urandom);
      @(posedge clk); #1;
      check("rand_switch", {20'h0, sw_o, rise, fall}, {20'h0, m_sw, m_rise, m_fall});
      check("rand_led", {28'h0, led_o}, {28'h0, m_led});
      check("rise_fall_exclusive", {28'h0, rise & fall}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
